booth_mul_sched: RTL and testbench

// Round-robin scheduler that shares one 4x4 signed Booth multiplier among NREQ requesters.

---
 rtl/booth_mul_sched.sv | 173 +++++++++++++++++
 tb/tb_booth_mul_sched.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/booth_mul_sched.sv
// Round-robin scheduler sharing one 4x4 signed Booth multiplier among NREQ requesters.
// One operation in flight; the response carries the requester id and a timeout error flag.
module booth_mul_sched #(
    parameter int NREQ    = 4,
    parameter int IDW     = $clog2(NREQ),
    parameter int TIMEOUT = 15
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NREQ-1:0]     req,
    input  logic [4*NREQ-1:0]   req_x,
    input  logic [4*NREQ-1:0]   req_y,
    output logic [NREQ-1:0]     req_ack,
    output logic                rsp_valid,
    output logic [IDW-1:0]      rsp_id,
    output logic [7:0]          rsp_data,
    output logic                rsp_err,
    output logic                busy,
    output logic                mul_start,
    output logic [3:0]          mul_x,
    output logic [3:0]          mul_y,
    input  logic                mul_valid,
    input  logic [7:0]          mul_z
);
    localparam int CW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_BUSY  = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [IDW-1:0]    rr_ptr_q, rr_ptr_d;
    logic [IDW-1:0]    id_q, id_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [NREQ-1:0]   req_ack_q, req_ack_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [IDW-1:0]    rsp_id_q, rsp_id_d;
    logic [7:0]        rsp_data_q, rsp_data_d;
    logic              rsp_err_q, rsp_err_d;
    logic              busy_q, busy_d;
    logic              mul_start_q, mul_start_d;
    logic [3:0]        mul_x_q, mul_x_d;
    logic [3:0]        mul_y_q, mul_y_d;

    logic              win_vld_s;
    logic [IDW-1:0]    win_id_s;
    int                pick_idx;
    int                win_off_s;

    // Round-robin pick: first set request at or after rr_ptr, wrapping around.
    always_comb begin
        win_vld_s = 1'b0;
        win_id_s  = '0;
        pick_idx  = 0;
        for (int k = 0; k < NREQ; k++) begin
            pick_idx = (int'(rr_ptr_q) + k) % NREQ;
            if (!win_vld_s && req[pick_idx]) begin
                win_vld_s = 1'b1;
                win_id_s  = IDW'(pick_idx);
            end else begin
                win_vld_s = win_vld_s;
            end
        end
        win_off_s = int'(win_id_s) * 4;
    end

    // Next-state and registered-output computation.
    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        id_d        = id_q;
        cnt_d       = cnt_q;
        req_ack_d   = '0;
        rsp_valid_d = 1'b0;
        rsp_err_d   = 1'b0;
        rsp_id_d    = rsp_id_q;
        rsp_data_d  = rsp_data_q;
        mul_start_d = 1'b0;
        mul_x_d     = mul_x_q;
        mul_y_d     = mul_y_q;
        case (state_q)
            S_IDLE: begin
                if (win_vld_s) begin
                    id_d                = win_id_s;
                    mul_x_d             = req_x[win_off_s +: 4];
                    mul_y_d             = req_y[win_off_s +: 4];
                    req_ack_d[win_id_s] = 1'b1;
                    if (win_id_s == IDW'(NREQ - 1)) begin
                        rr_ptr_d = '0;
                    end else begin
                        rr_ptr_d = win_id_s + IDW'(1);
                    end
                    state_d = S_ISSUE;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_ISSUE: begin
                mul_start_d = 1'b1;
                cnt_d       = '0;
                state_d     = S_BUSY;
            end
            S_BUSY: begin
                // Operands stay frozen here: the multiplier re-reads x every iteration.
                cnt_d = cnt_q + CW'(1);
                if (mul_valid) begin
                    rsp_valid_d = 1'b1;
                    rsp_data_d  = mul_z;
                    rsp_id_d    = id_q;
                    state_d     = S_IDLE;
                end else if (cnt_q == CW'(TIMEOUT - 1)) begin
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = 1'b1;
                    rsp_data_d  = 8'h00;
                    rsp_id_d    = id_q;
                    state_d     = S_IDLE;
                end else begin
                    state_d = S_BUSY;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        busy_d = (state_d != S_IDLE);
    end

    // State and output registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            rr_ptr_q    <= '0;
            id_q        <= '0;
            cnt_q       <= '0;
            req_ack_q   <= '0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= '0;
            rsp_data_q  <= 8'h00;
            rsp_err_q   <= 1'b0;
            busy_q      <= 1'b0;
            mul_start_q <= 1'b0;
            mul_x_q     <= 4'h0;
            mul_y_q     <= 4'h0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            id_q        <= id_d;
            cnt_q       <= cnt_d;
            req_ack_q   <= req_ack_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_id_q    <= rsp_id_d;
            rsp_data_q  <= rsp_data_d;
            rsp_err_q   <= rsp_err_d;
            busy_q      <= busy_d;
            mul_start_q <= mul_start_d;
            mul_x_q     <= mul_x_d;
            mul_y_q     <= mul_y_d;
        end
    end

    assign req_ack   = req_ack_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_id    = rsp_id_q;
    assign rsp_data  = rsp_data_q;
    assign rsp_err   = rsp_err_q;
    assign busy      = busy_q;
    assign mul_start = mul_start_q;
    assign mul_x     = mul_x_q;
    assign mul_y     = mul_y_q;

endmodule

// File: tb/tb_booth_mul_sched.sv
// Directed bench for booth_mul_sched with a 5-cycle multiplier stand-in that can be stalled.
module tb_booth_mul_sched;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [3:0]  req = 4'h0;
    logic [15:0] req_x = 16'h0000;
    logic [15:0] req_y = 16'h0000;
    logic [3:0]  req_ack;
    logic        rsp_valid;
    logic [1:0]  rsp_id;
    logic [7:0]  rsp_data;
    logic        rsp_err;
    logic        busy;
    logic        mul_start;
    logic [3:0]  mul_x;
    logic [3:0]  mul_y;
    logic        mul_valid;
    logic [7:0]  mul_z;

    logic        stall = 1'b0;
    logic        stray = 1'b0;
    logic        model_valid;
    logic [2:0]  mcnt;
    logic signed [7:0] prod_s;

    int total  = 0;
    int passed = 0;
    int n;
    logic seen;

    booth_mul_sched #(.NREQ(4), .IDW(2), .TIMEOUT(15)) dut (
        .clk(clk), .rst(rst), .req(req), .req_x(req_x), .req_y(req_y),
        .req_ack(req_ack), .rsp_valid(rsp_valid), .rsp_id(rsp_id),
        .rsp_data(rsp_data), .rsp_err(rsp_err), .busy(busy),
        .mul_start(mul_start), .mul_x(mul_x), .mul_y(mul_y),
        .mul_valid(mul_valid), .mul_z(mul_z)
    );

    always #5 clk = ~clk;

    assign prod_s    = $signed(mul_x) * $signed(mul_y);
    assign mul_valid = model_valid | stray;

    // Multiplier stand-in: valid pulses 5 cycles after the edge that samples start.
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            mcnt        <= 3'd0;
            model_valid <= 1'b0;
            mul_z       <= 8'h00;
        end else if (mul_start) begin
            mcnt        <= 3'd5;
            model_valid <= 1'b0;
            mul_z       <= prod_s;
        end else if (mcnt > 3'd1) begin
            mcnt        <= mcnt - 3'd1;
            model_valid <= 1'b0;
        end else if (mcnt == 3'd1) begin
            mcnt        <= 3'd0;
            model_valid <= !stall;
        end else begin
            model_valid <= 1'b0;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) begin
            passed++;
        end else begin
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic grant(input int id, input logic [3:0] x, input logic [3:0] y, input string tag);
        int k;
        req_x[4*id +: 4] = x;
        req_y[4*id +: 4] = y;
        req[id] = 1'b1;
        k = 0;
        do begin
            tick();
            k++;
        end while (req_ack == 4'h0 && k < 10);
        check({tag, "_ack"}, {28'h0, req_ack}, 32'h1 << id);
        req[id] = 1'b0;
    endtask

    task automatic wait_rsp(input int budget, output int cnt, input string tag);
        cnt = 0;
        while (rsp_valid !== 1'b1 && cnt < budget) begin
            tick();
            cnt++;
        end
        check({tag, "_rsp_seen"}, {31'h0, rsp_valid}, 32'h1);
    endtask

    task automatic check_rsp(input logic [7:0] d, input logic [1:0] id, input logic e, input string tag);
        check({tag, "_data"}, {24'h0, rsp_data}, {24'h0, d});
        check({tag, "_id"}, {30'h0, rsp_id}, {30'h0, id});
        check({tag, "_err"}, {31'h0, rsp_err}, {31'h0, e});
    endtask

    initial begin
        // Reset state
        #3;
        check("rst_busy", {31'h0, busy}, 32'h0);
        check("rst_ack", {28'h0, req_ack}, 32'h0);
        check("rst_mulxy", {24'h0, mul_x, mul_y}, 32'h0);
        check("rst_rsp", {20'h0, rsp_valid, rsp_err, rsp_id, rsp_data}, 32'h0);
        tick();
        rst = 1'b1;
        tick();

        // Single request: 3 * -2, exact latency
        grant(0, 4'd3, 4'hE, "t1");
        check("t1_busy", {31'h0, busy}, 32'h1);
        tick();
        check("t1_start_hi", {31'h0, mul_start}, 32'h1);
        check("t1_ack_pulse", {28'h0, req_ack}, 32'h0);
        tick();
        check("t1_start_lo", {31'h0, mul_start}, 32'h0);
        wait_rsp(20, n, "t1");
        check("t1_latency", n, 32'd6);
        check_rsp(8'hFA, 2'd0, 1'b0, "t1");
        tick();
        check("t1_rsp_pulse", {31'h0, rsp_valid}, 32'h0);
        check("t1_data_hold", {24'h0, rsp_data}, 32'hFA);
        check("t1_idle", {31'h0, busy}, 32'h0);

        // Corner products
        grant(1, 4'h8, 4'h8, "c1");
        wait_rsp(20, n, "c1");
        check_rsp(8'h40, 2'd1, 1'b0, "c1");
        grant(2, 4'h7, 4'h8, "c2");
        wait_rsp(20, n, "c2");
        check_rsp(8'hC8, 2'd2, 1'b0, "c2");
        grant(3, 4'h0, 4'h5, "c3");
        wait_rsp(20, n, "c3");
        check_rsp(8'h00, 2'd3, 1'b0, "c3");

        // Round robin with all requests held; rr_ptr is back at 0
        req_x = {4'd5, 4'hD, 4'd2, 4'hF};
        req_y = {4'd5, 4'd4, 4'd3, 4'hF};
        req   = 4'hF;
        for (int k = 0; k < 5; k++) begin
            n = 0;
            do begin
                tick();
                n++;
            end while (req_ack == 4'h0 && n < 10);
            check("rr_ack", {28'h0, req_ack}, 32'h1 << (k % 4));
            if (k == 4) req = 4'h0;
            wait_rsp(20, n, "rr");
            check("rr_id", {30'h0, rsp_id}, k % 4);
            case (k % 4)
                0: check("rr_data0", {24'h0, rsp_data}, 32'h01);
                1: check("rr_data1", {24'h0, rsp_data}, 32'h06);
                2: check("rr_data2", {24'h0, rsp_data}, 32'hF4);
                default: check("rr_data3", {24'h0, rsp_data}, 32'h19);
            endcase
        end

        // Stalled multiplier: timeout after 15 BUSY cycles
        stall = 1'b1;
        grant(1, 4'd1, 4'd1, "to");
        tick();
        check("to_start", {31'h0, mul_start}, 32'h1);
        wait_rsp(40, n, "to");
        check("to_cycles", n, 32'd15);
        check_rsp(8'h00, 2'd1, 1'b1, "to");
        stall = 1'b0;
        tick();
        check("to_err_pulse", {31'h0, rsp_err}, 32'h0);

        // Next request served; operands frozen while inputs toggle
        grant(2, 4'd6, 4'd7, "hold");
        n = 0;
        seen = 1'b0;
        while (rsp_valid !== 1'b1 && n < 20) begin
            req_x = ~req_x;
            req_y = ~req_y;
            tick();
            n++;
            if (mul_x !== 4'd6 || mul_y !== 4'd7) seen = 1'b1;
        end
        check("hold_mulxy_changed", {31'h0, seen}, 32'h0);
        check("hold_last_mulxy", {24'h0, mul_x, mul_y}, 32'h67);
        check_rsp(8'h2A, 2'd2, 1'b0, "hold");

        // Stray mul_valid in IDLE is ignored
        tick();
        stray = 1'b1;
        tick();
        stray = 1'b0;
        check("stray_rsp", {31'h0, rsp_valid}, 32'h0);
        check("stray_busy", {31'h0, busy}, 32'h0);

        // Asynchronous reset during BUSY
        grant(3, 4'd1, 4'd2, "rb");
        tick();
        tick();
        tick();
        check("rb_busy_before", {31'h0, busy}, 32'h1);
        #2 rst = 1'b0;
        #1;
        check("rb_busy", {31'h0, busy}, 32'h0);
        check("rb_mulxy", {24'h0, mul_x, mul_y}, 32'h0);
        check("rb_rsp", {20'h0, rsp_valid, rsp_err, rsp_id, rsp_data}, 32'h0);
        seen = 1'b0;
        for (int k = 0; k < 8; k++) begin
            tick();
            if (rsp_valid !== 1'b0) seen = 1'b1;
        end
        check("rb_no_rsp", {31'h0, seen}, 32'h0);
        rst = 1'b1;
        req_x = 16'hEE00;
        req_y = 16'hEE00;
        req = 4'b1100;
        tick();
        check("rb_first_grant", {28'h0, req_ack}, 32'h4);
        req = 4'h0;
        wait_rsp(20, n, "rb");
        check_rsp(8'h04, 2'd2, 1'b0, "rb");

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
